// File: rtl/multicycle_ctrl_hs_pkg.sv
// rtl/multicycle_ctrl_hs_pkg.sv - shared encodings for the multi-cycle controller
package cpu_pkg;

  localparam logic [3:0] OPC_LD   = 4'b0000;
  localparam logic [3:0] OPC_SW   = 4'b0001;
  localparam logic [3:0] OPC_J    = 4'b0010;
  localparam logic [3:0] OPC_BRZ  = 4'b0100;
  localparam logic [3:0] OPC_R    = 4'b1000;
  localparam logic [3:0] OPC_ADDI = 4'b1100;
  localparam logic [3:0] OPC_SUBI = 4'b1101;
  localparam logic [3:0] OPC_ANDI = 4'b1110;
  localparam logic [3:0] OPC_ORI  = 4'b1111;

  localparam logic [7:0] FN_MVTO = 8'h01;
  localparam logic [7:0] FN_MVFR = 8'h02;
  localparam logic [7:0] FN_ADD  = 8'h04;
  localparam logic [7:0] FN_SUB  = 8'h08;
  localparam logic [7:0] FN_AND  = 8'h10;
  localparam logic [7:0] FN_OR   = 8'h20;
  localparam logic [7:0] FN_NOT  = 8'h40;
  localparam logic [7:0] FN_NOP  = 8'h80;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_JMP = 2'b01, PC_BR = 2'b10} pc_sel_e;
  typedef enum logic [2:0] {WB_MEM = 3'b000, WB_MVTO = 3'b001, WB_MVFR = 3'b010,
                            WB_ALU = 3'b011, WB_NOT = 3'b100} wb_sel_e;
  typedef enum logic [1:0] {FLT_NONE = 2'b00, FLT_OPC = 2'b01, FLT_FUNC = 2'b10, FLT_BUS = 2'b11} fault_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LD, S_LD_WB, S_ST, S_JMP, S_BRZ,
    S_MVTO, S_MVFR, S_ALU_EX, S_IMM_EX, S_ALU_WB, S_NOT_WB, S_TRAP
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait counter that flags a bus timeout
module mem_wait_timer #(
  parameter int TMO_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW  = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam int LIM = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

  logic [CW-1:0] count_q, count_d;

  // Saturates so a disabled timeout never wraps into a false expiry.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != {CW{1'b1}}))
      count_d = count_q + 1'b1;
  end

  // Fires on the wait cycle whose increment would reach TMO_CYC.
  assign expired = (TMO_CYC > 0) && en && (count_q == CW'(LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// rtl/multicycle_ctrl_hs.sv - multi-cycle CPU control FSM with memory handshake and fault trap
module multicycle_ctrl_hs
  import cpu_pkg::*;
#(
  parameter int INST_W  = 16,
  parameter int OPC_W   = 4,
  parameter int FUNC_W  = 9,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] Inst,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_adr_sel,
  output logic              IR_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_sel,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_write_en,
  output logic              reg_write_adr,
  output logic [2:0]        reg_write_sel,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  state_e state_q, state_d, dec_next;
  fault_e fault_code_q, fault_code_d, dec_fault;

  logic [OPC_W-1:0]  opcode;
  logic [FUNC_W-1:0] func;
  logic [7:0]        func8;
  logic              opc_hi_zero, func_ok;
  logic              tmr_en, tmr_expired;

  assign opcode      = Inst[INST_W-1 -: OPC_W];
  assign func        = Inst[FUNC_W-1:0];
  assign func8       = func[7:0];
  assign opc_hi_zero = ((opcode >> 4) == '0);
  assign func_ok     = ((func >> 8) == '0) && $onehot(func);

  assign tmr_en = (state_q inside {S_FETCH, S_LD, S_ST}) && !mem_ready;

  mem_wait_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    dec_next  = S_TRAP;
    dec_fault = FLT_OPC;
    if (opc_hi_zero) begin
      case (opcode[3:0])
        OPC_LD:  dec_next = S_LD;
        OPC_SW:  dec_next = S_ST;
        OPC_J:   dec_next = S_JMP;
        OPC_BRZ: dec_next = S_BRZ;
        OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI: dec_next = S_IMM_EX;
        OPC_R: begin
          dec_fault = FLT_FUNC;
          if (func_ok) begin
            case (func8)
              FN_MVTO: dec_next = S_MVTO;
              FN_MVFR: dec_next = S_MVFR;
              FN_ADD, FN_SUB, FN_AND, FN_OR: dec_next = S_ALU_EX;
              FN_NOT:  dec_next = S_NOT_WB;
              FN_NOP:  dec_next = S_FETCH;
              default: dec_next = S_TRAP;
            endcase
          end
        end
        default: dec_next = S_TRAP;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    fault_code_d  = fault_code_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_adr_sel   = 1'b0;
    IR_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_sel        = PC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_write_en  = 1'b0;
    reg_write_adr = 1'b0;
    reg_write_sel = WB_MEM;
    busy          = 1'b1;
    fault         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        if (mem_ready) begin
          IR_write = 1'b1;
          pc_write = 1'b1;
          busy     = 1'b0;
          state_d  = S_DECODE;
        end else if (tmr_expired) begin
          state_d      = S_TRAP;
          fault_code_d = FLT_BUS;
        end
      end
      S_DECODE: begin
        state_d = dec_next;
        if (dec_next == S_TRAP)
          fault_code_d = dec_fault;
      end
      S_LD, S_ST: begin
        mem_read    = (state_q == S_LD);
        mem_write   = (state_q == S_ST);
        mem_adr_sel = 1'b1;
        if (mem_ready) begin
          state_d = (state_q == S_LD) ? S_LD_WB : S_FETCH;
        end else if (tmr_expired) begin
          state_d      = S_TRAP;
          fault_code_d = FLT_BUS;
        end
      end
      S_LD_WB: begin
        reg_write_en = 1'b1;
        state_d      = S_FETCH;
      end
      S_JMP: begin
        pc_write = 1'b1;
        pc_sel   = PC_JMP;
        state_d  = S_FETCH;
      end
      S_BRZ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_sel        = PC_BR;
        state_d       = S_FETCH;
      end
      S_MVTO: begin
        reg_write_en  = 1'b1;
        reg_write_adr = 1'b1;
        reg_write_sel = WB_MVTO;
        state_d       = S_FETCH;
      end
      S_MVFR: begin
        reg_write_en  = 1'b1;
        reg_write_sel = WB_MVFR;
        state_d       = S_FETCH;
      end
      S_ALU_EX: begin
        alu_src_a = 1'b1;
        case (func8)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = opcode[1:0];
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_en  = 1'b1;
        reg_write_sel = WB_ALU;
        state_d       = S_FETCH;
      end
      S_NOT_WB: begin
        reg_write_en  = 1'b1;
        reg_write_sel = WB_NOT;
        state_d       = S_FETCH;
      end
      S_TRAP: fault = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Strobes must fall the moment reset hits, not at the next edge.
    if (rst) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      IR_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write_en  = 1'b0;
    end
  end

  assign fault_code = fault_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// tb/tb_multicycle_ctrl_hs.sv - directed and randomized checks of the controller against a cycle model
module tb_multicycle_ctrl_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Inst;
  logic        mem_ready;
  logic        mem_read, mem_write, mem_adr_sel, IR_write, pc_write, pc_write_cond;
  logic [1:0]  pc_sel, alu_src_b, alu_op, fault_code;
  logic        alu_src_a, reg_write_en, reg_write_adr, busy, fault;
  logic [2:0]  reg_write_sel;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       mr, mw, as, irw, pcw, pcc;
    logic [1:0] ps;
    logic       sa;
    logic [1:0] sb, op;
    logic       rwe, rwa;
    logic [2:0] rws;
    logic       bsy, flt;
    logic [1:0] fc;
  } ctl_t;

  typedef struct packed {
    logic rdy;
    ctl_t c;
  } step_t;

  step_t q[$];

  multicycle_ctrl_hs #(.INST_W(16), .OPC_W(4), .FUNC_W(9), .TMO_CYC(15)) dut (
    .clk(clk), .rst(rst), .Inst(Inst), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_adr_sel(mem_adr_sel),
    .IR_write(IR_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write_en(reg_write_en), .reg_write_adr(reg_write_adr), .reg_write_sel(reg_write_sel),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t c;
    c.mr = mem_read;  c.mw = mem_write; c.as = mem_adr_sel; c.irw = IR_write;
    c.pcw = pc_write; c.pcc = pc_write_cond; c.ps = pc_sel; c.sa = alu_src_a;
    c.sb = alu_src_b; c.op = alu_op; c.rwe = reg_write_en; c.rwa = reg_write_adr;
    c.rws = reg_write_sel; c.bsy = busy; c.flt = fault; c.fc = fault_code;
    return c;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t got, input ctl_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model: expected control per cycle ----------------
  function automatic ctl_t busy_idle();
    ctl_t c = '0;
    c.bsy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_ctl(input bit rdy);
    ctl_t c = '0;
    c.mr = 1'b1; c.sb = 2'b01;
    c.irw = rdy; c.pcw = rdy; c.bsy = !rdy;
    return c;
  endfunction

  function automatic ctl_t trap_ctl(input logic [1:0] code);
    ctl_t c = '0;
    c.bsy = 1'b1; c.flt = 1'b1; c.fc = code;
    return c;
  endfunction

  function automatic ctl_t wb_ctl(input logic adr, input logic [2:0] sel);
    ctl_t c = busy_idle();
    c.rwe = 1'b1; c.rwa = adr; c.rws = sel;
    return c;
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input bit r, input ctl_t c);
    step_t s;
    s.rdy = r;
    s.c   = c;
    q.push_back(s);
  endfunction

  function automatic void add_fetch(input int w);
    for (int k = 0; k < w; k++) push(1'b0, fetch_ctl(1'b0));
    push(1'b1, fetch_ctl(1'b1));
  endfunction

  // Returns 0 legal, 1 illegal opcode, 2 illegal func.
  function automatic int classify(input logic [15:0] inst);
    logic [3:0] op = inst[15:12];
    logic [8:0] fn = inst[8:0];
    if (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'hC, 4'hD, 4'hE, 4'hF}) return 0;
    if (op != 4'h8) return 1;
    return ($countones(fn) == 1 && !fn[8]) ? 0 : 2;
  endfunction

  function automatic void add_inst(input logic [15:0] inst, input int wf, input int wd);
    ctl_t c;
    logic [3:0] op = inst[15:12];
    logic [8:0] fn = inst[8:0];
    int code = classify(inst);
    int p = 0;
    add_fetch(wf);
    push(rnd(), busy_idle());
    if (code != 0) begin
      for (int k = 0; k < 4; k++) push(rnd(), trap_ctl(2'(code)));
      return;
    end
    c = busy_idle();
    case (op)
      4'h0, 4'h1: begin
        c.as = 1'b1;
        if (op == 4'h0) c.mr = 1'b1; else c.mw = 1'b1;
        for (int k = 0; k < wd; k++) push(1'b0, c);
        push(1'b1, c);
        if (op == 4'h0) push(rnd(), wb_ctl(1'b0, 3'b000));
      end
      4'h2: begin c.pcw = 1'b1; c.ps = 2'b01; push(rnd(), c); end
      4'h4: begin c.sa = 1'b1; c.op = 2'b01; c.pcc = 1'b1; c.ps = 2'b10; push(rnd(), c); end
      4'h8: begin
        for (int b = 0; b < 8; b++) if (fn[b]) p = b;
        if (p == 0) push(rnd(), wb_ctl(1'b1, 3'b001));
        else if (p == 1) push(rnd(), wb_ctl(1'b0, 3'b010));
        else if (p <= 5) begin
          c.sa = 1'b1; c.op = 2'(p - 2);
          push(rnd(), c);
          push(rnd(), wb_ctl(1'b0, 3'b011));
        end
        else if (p == 6) push(rnd(), wb_ctl(1'b0, 3'b100));
      end
      default: begin
        c.sa = 1'b1; c.sb = 2'b10; c.op = op[1:0];
        push(rnd(), c);
        push(rnd(), wb_ctl(1'b0, 3'b011));
      end
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last queued cycle.
  task automatic run_q(input string tag, input logic [15:0] inst);
    step_t s;
    Inst = inst;
    for (int i = 0; i < q.size(); i++) begin
      s = q[i];
      mem_ready = s.rdy;
      #2;
      chk_ctl($sformatf("%s[%0d]", tag, i), sample(), s.c);
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic do_reset();
    ctl_t c = fetch_ctl(1'b0);
    c.mr = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b0;
    #2;
    chk_ctl("reset_ctl", sample(), c);
    chk_val("reset_cnt", int'(dut.u_timer.count_q), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [15:0] rand_inst();
    logic [15:0] v = 16'($urandom);
    int r = $urandom_range(0, 11);
    logic [8:0] bad [5] = '{9'h000, 9'h100, 9'h003, 9'h0C0, 9'h1FF};
    logic [3:0] badop [7] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB};
    case (r)
      0: v[15:12] = 4'h0;
      1: v[15:12] = 4'h1;
      2: v[15:12] = 4'h2;
      3: v[15:12] = 4'h4;
      5, 6: v[15:12] = {2'b11, 2'($urandom)};
      7: v[15:12] = badop[$urandom_range(0, 6)];
      8: begin v[15:12] = 4'h8; v[8:0] = bad[$urandom_range(0, 4)]; end
      default: begin v[15:12] = 4'h8; v[8:0] = 9'(1 << $urandom_range(0, 7)); end
    endcase
    return v;
  endfunction

  initial begin
    ctl_t c;
    logic [15:0] ri;
    Inst = 16'h0000;
    do_reset();

    add_inst(16'hC005, 0, 0);     run_q("addi", 16'hC005);
    add_inst(16'h0123, 0, 3);     run_q("ld_wait3", 16'h0123);
    add_inst(16'h1042, 2, 14);    run_q("sw_ready_at_limit", 16'h1042);
    add_inst(16'h4000, 0, 0);     run_q("brz", 16'h4000);
    add_inst(16'h8080, 0, 0);     run_q("nop", 16'h8080);
    add_inst(16'h2ABC, 14, 0);    run_q("j_fetch_limit", 16'h2ABC);

    // sw never acknowledged: 15 wait cycles then bus-timeout trap
    add_fetch(0);
    push(1'b0, busy_idle());
    c = busy_idle(); c.mw = 1'b1; c.as = 1'b1;
    for (int k = 0; k < 15; k++) push(1'b0, c);
    for (int k = 0; k < 3; k++) push(rnd(), trap_ctl(2'b11));
    run_q("sw_timeout", 16'h1000);
    do_reset();

    add_inst(16'h3000, 1, 0);     run_q("illegal_opc", 16'h3000);
    run_q("illegal_opc_sticky", 16'hC005);
    add_fetch(0);  // queue cleared below: trap holds regardless of input
    q.delete();
    for (int k = 0; k < 3; k++) push(rnd(), trap_ctl(2'b01));
    run_q("illegal_opc_hold", 16'h8006);
    do_reset();

    add_inst(16'h8006, 0, 0);     run_q("illegal_func", 16'h8006);
    do_reset();

    // fetch that never completes also times out
    for (int k = 0; k < 15; k++) push(1'b0, fetch_ctl(1'b0));
    push(rnd(), trap_ctl(2'b11));
    run_q("fetch_timeout", 16'h0000);
    do_reset();

    // asynchronous reset while LD waits
    add_fetch(0);
    push(1'b0, busy_idle());
    c = busy_idle(); c.mr = 1'b1; c.as = 1'b1;
    push(1'b0, c); push(1'b0, c);
    run_q("ld_pre_rst", 16'h0055);
    mem_ready = 1'b0;
    #2;
    chk_ctl("ld_wait_before_rst", sample(), c);
    chk_val("cnt_before_rst", int'(dut.u_timer.count_q), 2);
    rst = 1'b1;
    #1;
    chk_val("mem_read_on_rst", int'(mem_read), 0);
    chk_val("adr_sel_on_rst", int'(mem_adr_sel), 0);
    chk_val("cnt_on_rst", int'(dut.u_timer.count_q), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_inst(16'h0055, 1, 1);     run_q("ld_after_rst", 16'h0055);

    for (int n = 0; n < 60; n++) begin
      ri = rand_inst();
      add_inst(ri, rand_wait(), rand_wait());
      run_q($sformatf("rand%0d_%h", n, ri), ri);
      if (classify(ri) != 0) do_reset();
    end

    push(1'b0, fetch_ctl(1'b0));
    run_q("final_fetch", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl_hs.md
Name: multicycle_ctrl_hs

Overview:
- Next-generation multi-cycle controller FSM for the 16-bit accumulator/register CPU. It decodes the IR and sequences the datapath: PC, IR, register file, ALU and memory muxes.
- Adds a variable-latency memory handshake (mem_ready), a configurable bus-timeout, illegal-instruction trapping and a sticky fault status.
- Instruction field widths are parametrised.
- Sits between the IR/datapath and the unified instruction/data memory port.

Parameters:
INST_W, 16, instruction width; opcode = Inst[INST_W-1 -: OPC_W].
OPC_W, 4, opcode width (≥4; only low-4 encodings defined, upper bits must be 0).
FUNC_W, 9, R-type one-hot function field = Inst[FUNC_W-1:0] (≥8).
TMO_CYC, 15, max wait cycles for mem_ready before bus fault; 0 disables timeout.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
Inst  in  INST_W  current IR contents.
mem_ready  in  1  memory completes the current access this cycle.
mem_read  out  1  read request.
mem_write  out  1  write request.
mem_adr_sel  out  1  0=PC, 1=data address.
IR_write  out  1  load IR.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load if ALU zero.
pc_sel  out  2  00 ALU, 01 jump target, 10 branch target.
alu_src_a  out  1  0=PC, 1=register.
alu_src_b  out  2  00 register, 01 constant 1, 10 immediate.
alu_op  out  2  00 add, 01 sub, 10 and, 11 or.
reg_write_en  out  1  register-file write.
reg_write_adr  out  1  0=R0/acc, 1=Ri.
reg_write_sel  out  3  000 mem, 001 move_to, 010 move_from, 011 ALU, 100 not.
busy  out  1  high in every state except FETCH-with-no-request-pending (see below).
fault  out  1  sticky; high in TRAP.
fault_code  out  2  00 none, 01 illegal opcode, 10 illegal func, 11 bus timeout.

Behaviour:
- All outputs are Moore/Mealy combinational from state (+Inst, mem_ready). Every control output defaults to 0 each cycle.
- Reset: state=FETCH, timeout counter=0, fault_code=00. All outputs 0 except FETCH defaults.
- Opcodes:
  - 0000 ld, 0001 sw, 0010 j, 0100 brz, 1000 R-type.
  - 1100 addi, 1101 subi, 1110 andi, 1111 ori.
  - Any other value, or nonzero upper opcode bits, is illegal.
- R-type func codes (exactly one-hot, upper bits 0): bit0 move_to, bit1 move_from, bit2 add, bit3 sub, bit4 and, bit5 or, bit6 not, bit7 nop. Anything else is illegal func.
- States and transitions:
  - FETCH: mem_read=1, mem_adr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_sel=00.
    - IR_write and pc_write are asserted only in the cycle mem_ready=1; that cycle goes to DECODE, otherwise stay.
    - busy=0 only in FETCH when mem_ready=1.
  - DECODE: no outputs.
    - ld→LD, sw→ST, j→JMP, brz→BRZ, imm→IMM_EX.
    - R: move_to→MVTO, move_from→MVFR, add/sub/and/or→ALU_EX, not→NOT_WB, nop→FETCH.
    - Illegal→TRAP.
  - LD: mem_read=1, mem_adr_sel=1; when mem_ready go to LD_WB.
  - LD_WB: reg_write_en=1, adr=0, sel=000; then FETCH.
  - ST: mem_write=1, mem_adr_sel=1; when mem_ready go to FETCH. No register write.
  - JMP: pc_write=1, pc_sel=01; then FETCH.
  - BRZ: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_sel=10; then FETCH.
  - MVTO: reg_write_en=1, adr=1, sel=001; then FETCH.
  - MVFR: reg_write_en=1, adr=0, sel=010; then FETCH.
  - ALU_EX: alu_src_a=1, alu_src_b=00, alu_op from func; then ALU_WB.
  - IMM_EX: alu_src_a=1, alu_src_b=10, alu_op from opcode low 2 bits; then ALU_WB.
  - ALU_WB: reg_write_en=1, adr=0, sel=011; then FETCH.
  - NOT_WB: reg_write_en=1, adr=0, sel=100; then FETCH.
  - TRAP: all controls 0, fault=1, busy=1. Stays until rst.
- Timeout:
  - Counter increments in FETCH/LD/ST while mem_ready=0 and clears on leaving the state or on mem_ready.
  - If TMO_CYC>0 and the counter reaches TMO_CYC with mem_ready still 0, go to TRAP with code 11. Request outputs drop in TRAP.
  - mem_ready in the same cycle the count hits TMO_CYC wins: normal transition, no fault.
- fault_code is latched on TRAP entry and never overwritten until rst.
- rst asserted mid-access: immediate return to FETCH, requests drop asynchronously.
- Instruction latencies with zero-wait memory:
  - 3 cycles: j, brz, move_to, move_from, not, sw.
  - 4 cycles: ALU, immediate, ld.
  - 2 cycles: nop.

Decomposition:
- Shared package (cpu_pkg): opcode constants, one-hot func constants, alu_op / alu_src_b / pc_sel / reg_write_sel / fault_code encodings, state enum.
- One sub-module: mem_wait_timer (TMO_CYC-parametrised counter with clear/enable, expired output).

Test Plan:
- addi 5 (Inst=16'hC005), mem_ready=1 always → states FETCH, DECODE, IMM_EX (alu_src_b=10, alu_op=00), ALU_WB (reg_write_en=1, sel=011), back to FETCH on cycle 5.
- ld with mem_ready low 3 cycles in LD → mem_read held 4 cycles, then LD_WB sel=000. fault stays 0.
- sw, mem_ready never asserted, TMO_CYC=15 → TRAP after exactly 15 wait cycles, fault_code=11, mem_write=0 from the trap cycle on.
- Opcode 4'b0011, then func 9'b000000110 (two bits set) → TRAP with fault_code=01, then 10 respectively. Only rst clears it.
- brz (Inst=16'h4000) → pc_write_cond=1, pc_sel=10, alu_op=01 for one cycle. nop (16'h8080) → returns to FETCH with no write strobes.
- rst pulse asynchronous during LD wait → mem_read falls in the same cycle, state=FETCH, counter=0.
